// File: rtl/vga_pkg.sv
// Shared types for the VGA pixel pipeline: colour, grid description and
// line-fetch FSM state encoding.
package vga_pkg;

  typedef logic [2:0] vga_color_t;

  typedef struct packed {
    logic [3:0] cell_w_log2;
    logic [3:0] cell_h_log2;
    logic [5:0] grid_cols;
    logic [7:0] grid_rows;
    vga_color_t bg_color;
  } vga_grid_params_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vga_line_buffer.sv
// One grid row of cell colours: synchronous write, combinational read,
// synchronous clear to the background colour.
module vga_line_buffer
  import vga_pkg::*;
#(
  parameter int         DEPTH    = 10,
  parameter int         IDX_BITS = 4,
  parameter vga_color_t BG_COLOR = 3'b000
) (
  input  logic                VGA_clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  vga_color_t          wr_data,
  input  logic [IDX_BITS-1:0] rd_idx,
  output vga_color_t          rd_data
);

  vga_color_t mem [DEPTH];

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= BG_COLOR;
    end else if (wr_en && (32'(wr_idx) < 32'(DEPTH))) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_idx) < 32'(DEPTH)) ? mem[rd_idx] : BG_COLOR;

endmodule

// File: rtl/vga_cell_line_fetcher.sv
// Cell-grid pixel source: prefetches the next grid row from cell RAM during
// h-blank, then serves pixel colours combinationally from the line buffer.
module vga_cell_line_fetcher
  import vga_pkg::*;
#(
  parameter int         H_VISIBLE    = 640,
  parameter int         V_VISIBLE    = 480,
  parameter int         PIXEL_X_BITS = 10,
  parameter int         PIXEL_Y_BITS = 10,
  parameter int         CELL_W_LOG2  = 4,
  parameter int         CELL_H_LOG2  = 4,
  parameter int         GRID_COLS    = 10,
  parameter int         GRID_ROWS    = 20,
  parameter vga_color_t BG_COLOR     = 3'b000,
  parameter int         ADDR_BITS    = $clog2(GRID_COLS*GRID_ROWS)
) (
  input  logic                    VGA_clk,
  input  logic                    reset,
  input  logic [PIXEL_X_BITS-1:0] pixel_x,
  input  logic [PIXEL_Y_BITS-1:0] pixel_y,
  output logic                    cell_rd_en,
  output logic [ADDR_BITS-1:0]    cell_rd_addr,
  input  logic [2:0]              cell_rd_data,
  output logic                    pixel_value_next_R,
  output logic                    pixel_value_next_G,
  output logic                    pixel_value_next_B,
  output logic                    frame_tick,
  output logic                    fetch_busy,
  output logic                    overrun,
  output logic [1:0]              fetch_state
);

  localparam int         COL_BITS = $clog2(GRID_COLS+1);
  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_FETCH  = 2'(FETCH);
  localparam logic [1:0] S_DRAIN  = 2'(DRAIN);

  logic [1:0]              state;
  logic [ADDR_BITS-1:0]    row;
  logic [COL_BITS-1:0]     col;
  logic                    row_valid;
  logic                    trigger;
  logic                    last_line;
  logic                    row_in_grid;
  logic [PIXEL_Y_BITS-1:0] next_y;
  logic [PIXEL_Y_BITS-1:0] next_row;
  logic [PIXEL_X_BITS-1:0] cell_x;
  logic                    buf_wr_en;
  logic [COL_BITS-1:0]     buf_wr_idx;
  vga_color_t              buf_rd_data;
  vga_color_t              pix_color;

  assign trigger     = (pixel_x == PIXEL_X_BITS'(H_VISIBLE-1));
  assign last_line   = (pixel_y == PIXEL_Y_BITS'(V_VISIBLE-1));
  // v-blank holds pixel_y at 0, so next_y=1 still lands in grid row 0.
  assign next_y      = last_line ? '0 : pixel_y + PIXEL_Y_BITS'(1);
  assign next_row    = next_y >> CELL_H_LOG2;
  assign row_in_grid = (32'(next_row) < 32'(GRID_ROWS));

  assign fetch_state  = state;
  assign fetch_busy   = (state != S_IDLE);
  assign frame_tick   = !reset && trigger && last_line;
  assign cell_rd_en   = (state == S_FETCH);
  assign cell_rd_addr = cell_rd_en ?
                        (ADDR_BITS'(row * ADDR_BITS'(GRID_COLS)) + ADDR_BITS'(col)) : '0;

  // RAM data lags the strobe by one cycle, so the word for col-1 lands now.
  assign buf_wr_en  = ((state == S_FETCH) && (col != '0)) || (state == S_DRAIN);
  assign buf_wr_idx = col - COL_BITS'(1);

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      row_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (fetch_busy && (trigger || (pixel_x == PIXEL_X_BITS'(1)))) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            if (row_in_grid) begin
              row   <= ADDR_BITS'(next_row);
              col   <= '0;
              state <= S_FETCH;
            end else begin
              row_valid <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          col <= col + COL_BITS'(1);
          if (col == COL_BITS'(GRID_COLS-1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          row_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  vga_line_buffer #(
    .DEPTH   (GRID_COLS),
    .IDX_BITS(COL_BITS),
    .BG_COLOR(BG_COLOR)
  ) u_line_buf (
    .VGA_clk(VGA_clk),
    .reset  (reset),
    .wr_en  (buf_wr_en),
    .wr_idx (buf_wr_idx),
    .wr_data(cell_rd_data),
    .rd_idx (cell_x[COL_BITS-1:0]),
    .rd_data(buf_rd_data)
  );

  assign cell_x    = pixel_x >> CELL_W_LOG2;
  assign pix_color = (row_valid && (32'(cell_x) < 32'(GRID_COLS))) ? buf_rd_data : BG_COLOR;
  assign {pixel_value_next_R, pixel_value_next_G, pixel_value_next_B} = pix_color;

endmodule

// File: tb/tb_vga_cell_line_fetcher.sv
// Bench for vga_cell_line_fetcher: line sweeps with a RAM model, lookup vector
// tables, and hand sequences for reset-abort and overrun.
module tb_vga_cell_line_fetcher;

  logic       VGA_clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       cell_rd_en;
  logic [7:0] cell_rd_addr;
  logic [2:0] cell_rd_data = '0;
  logic       pixel_value_next_R, pixel_value_next_G, pixel_value_next_B;
  logic       frame_tick, fetch_busy, overrun;
  logic [1:0] fetch_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] rgb;
  } vec_t;

  vec_t row1_vec[10];
  vec_t row0_vec[7];
  vec_t bg_vec[4];

  vga_cell_line_fetcher dut (
    .VGA_clk           (VGA_clk),
    .reset             (reset),
    .pixel_x           (pixel_x),
    .pixel_y           (pixel_y),
    .cell_rd_en        (cell_rd_en),
    .cell_rd_addr      (cell_rd_addr),
    .cell_rd_data      (cell_rd_data),
    .pixel_value_next_R(pixel_value_next_R),
    .pixel_value_next_G(pixel_value_next_G),
    .pixel_value_next_B(pixel_value_next_B),
    .frame_tick        (frame_tick),
    .fetch_busy        (fetch_busy),
    .overrun           (overrun),
    .fetch_state       (fetch_state)
  );

  // clock / reset
  always #5 VGA_clk = ~VGA_clk;

  // cell RAM model: data = addr[2:0], one-cycle read latency
  always @(posedge VGA_clk) begin
    if (cell_rd_en) cell_rd_data <= cell_rd_addr[2:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every RAM strobe must match the next expected address
  always @(negedge VGA_clk) begin
    if (cell_rd_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got addr %0d expected no read", cell_rd_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_addr", cell_rd_addr, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge VGA_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pixel_x = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic run_line(input int y);
    int nr;
    bit in_grid;
    nr = ((y == 479) ? 0 : y + 1) >> 4;
    in_grid = (nr < 20);
    for (int x = 0; x < 800; x++) begin
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      #1;
      if (x == 639) begin
        check($sformatf("frame_tick_y%0d", y), frame_tick, 32'(y == 479));
        if (in_grid) for (int c = 0; c < 10; c++) exp_q.push_back(8'(nr*10 + c));
      end
      if (x == 640) check("frame_tick_drop", frame_tick, 0);
      if (x == 650) check($sformatf("busy_drain_y%0d", y), fetch_busy, 32'(in_grid));
      if (x == 651) check($sformatf("busy_done_y%0d", y), fetch_busy, 0);
      tick();
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    pixel_x = 10'(v.x);
    pixel_y = 10'(v.y);
    #1;
    check(tag, {pixel_value_next_R, pixel_value_next_G, pixel_value_next_B}, v.rgb);
    tick();
  endtask

  task automatic check_rgb(input int x, input logic [2:0] exp, input string tag);
    pixel_x = 10'(x);
    #1;
    check(tag, {pixel_value_next_R, pixel_value_next_G, pixel_value_next_B}, exp);
  endtask

  initial begin
    row1_vec = '{'{0, 16, 3'b010}, '{15, 16, 3'b010}, '{16, 16, 3'b011}, '{31, 16, 3'b011},
                 '{32, 16, 3'b100}, '{80, 16, 3'b111}, '{159, 16, 3'b011}, '{160, 16, 3'b000},
                 '{600, 16, 3'b000}, '{799, 16, 3'b000}};
    row0_vec = '{'{0, 0, 3'b000}, '{16, 0, 3'b001}, '{48, 0, 3'b011}, '{112, 0, 3'b111},
                 '{128, 0, 3'b000}, '{144, 0, 3'b001}, '{170, 0, 3'b000}};
    bg_vec   = '{'{0, 320, 3'b000}, '{16, 320, 3'b000}, '{80, 320, 3'b000}, '{159, 320, 3'b000}};

    // reset state
    do_reset();
    check("rst_busy", fetch_busy, 0);
    check("rst_rd_en", cell_rd_en, 0);
    check("rst_rd_addr", cell_rd_addr, 0);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_overrun", overrun, 0);
    check_rgb(50, 3'b000, "rst_rgb");
    tick();

    // row 1 fetch, then lookup table
    run_line(15);
    for (int i = 0; i < 10; i++) apply_vec(row1_vec[i], $sformatf("row1_vec[%0d]", i));

    // out-of-grid row clears the line
    run_line(319);
    for (int i = 0; i < 4; i++) apply_vec(bg_vec[i], $sformatf("bg_vec[%0d]", i));

    // last visible line: frame tick and wrap to row 0
    run_line(479);
    for (int i = 0; i < 7; i++) apply_vec(row0_vec[i], $sformatf("row0_vec[%0d]", i));
    check("overrun_quiet", overrun, 0);

    // reset on the 4th FETCH cycle aborts the fetch
    pixel_x = 10'd639;
    pixel_y = 10'd31;
    for (int c = 0; c < 10; c++) exp_q.push_back(8'(20 + c));
    tick();
    for (int k = 0; k < 3; k++) begin
      pixel_x = 10'(640 + k);
      tick();
    end
    pixel_x = 10'd643;
    reset = 1'b1;
    #1;
    check("abort_pre_rd_en", cell_rd_en, 1);
    tick();
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", fetch_busy, 0);
    check("abort_rd_en", cell_rd_en, 0);
    check_rgb(16, 3'b000, "abort_rgb16");
    check_rgb(0, 3'b000, "abort_rgb0");
    tick();

    // second trigger 5 cycles into a fetch
    pixel_x = 10'd639;
    pixel_y = 10'd15;
    for (int c = 0; c < 10; c++) exp_q.push_back(8'(10 + c));
    tick();
    for (int k = 0; k < 4; k++) begin
      pixel_x = 10'(640 + k);
      tick();
    end
    check("ovr_before", overrun, 0);
    pixel_x = 10'd639;
    tick();
    check("ovr_retrigger", overrun, 1);
    for (int k = 0; k < 12; k++) begin
      pixel_x = 10'(645 + k);
      tick();
    end
    check("ovr_busy_end", fetch_busy, 0);
    check("ovr_sticky", overrun, 1);
    pixel_y = 10'd16;
    check_rgb(16, 3'b011, "ovr_row_intact");
    tick();

    // pixel_x==1 while busy
    do_reset();
    check("ovr_cleared", overrun, 0);
    pixel_x = 10'd639;
    pixel_y = 10'd15;
    for (int c = 0; c < 10; c++) exp_q.push_back(8'(10 + c));
    tick();
    pixel_x = 10'd0;
    tick();
    pixel_x = 10'd1;
    #1;
    check("ovr_x1_pre", overrun, 0);
    tick();
    check("ovr_x1", overrun, 1);
    for (int k = 0; k < 12; k++) begin
      pixel_x = 10'(2 + k);
      tick();
    end
    check("final_busy", fetch_busy, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_cell_line_fetcher.md
Name: vga_cell_line_fetcher

Overview:
- Pixel source directly upstream of the VGA timing controller, in the VGA_clk domain.
- Consumes the controller's pixel_x_target_next / pixel_y_target_next and returns pixel_value_next_R/G/B in the same cycle (combinational).
- Renders a coarse cell grid (e.g. a 10x20 game board) held in an external synchronous-read cell RAM of 3-bit colors.
- During each horizontal blank it prefetches one grid row into a local line buffer, so visible-region lookup needs no RAM access.

Parameters:
- H_VISIBLE, 640, visible pixels per line.
- V_VISIBLE, 480, visible lines per frame.
- PIXEL_X_BITS, 10, width of pixel_x.
- PIXEL_Y_BITS, 10, width of pixel_y.
- CELL_W_LOG2, 4, log2 of cell width in pixels.
- CELL_H_LOG2, 4, log2 of cell height in pixels; must be >= 1.
- GRID_COLS, 10, cells per row; must be < 63.
- GRID_ROWS, 20, rows in the grid.
- BG_COLOR, 3'b000, {R,G,B} shown outside the grid and after reset.
- ADDR_BITS, $clog2(GRID_COLS*GRID_ROWS), cell RAM address width.

Ports:
- VGA_clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- pixel_x  in  PIXEL_X_BITS  from controller pixel_x_target_next; 0 during h-blank.
- pixel_y  in  PIXEL_Y_BITS  from controller pixel_y_target_next; 0 during v-blank.
- cell_rd_en  out  1  cell RAM read strobe.
- cell_rd_addr  out  ADDR_BITS  row*GRID_COLS+col.
- cell_rd_data  in  3  {R,G,B}; valid the cycle after cell_rd_en.
- pixel_value_next_R  out  1  red bit for (pixel_x, pixel_y), combinational.
- pixel_value_next_G  out  1  green bit, combinational.
- pixel_value_next_B  out  1  blue bit, combinational.
- frame_tick  out  1  one-cycle pulse at end of the last visible line.
- fetch_busy  out  1  high while a row fetch is in progress.
- overrun  out  1  sticky; fetch still active when visible pixels resumed.

Behaviour:
- Reset (synchronous): state=IDLE, line buffer all BG_COLOR, row_valid=0, cell_rd_en=0, cell_rd_addr=0, frame_tick=0, fetch_busy=0, overrun=0.
  - Reset during a fetch aborts it immediately.
- Trigger: asserted in the cycle pixel_x==H_VISIBLE-1.
  - next_y = (pixel_y==V_VISIBLE-1) ? 0 : pixel_y+1.
  - next_row = next_y >> CELL_H_LOG2.
  - During v-blank pixel_y reads 0, so next_y=1 maps to row 0. This is why CELL_H_LOG2>=1 is required.
- frame_tick: high in the trigger cycle when pixel_y==V_VISIBLE-1; low otherwise.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE, trigger with next_row>=GRID_ROWS: row_valid<=0, stay in IDLE, no RAM reads.
  - IDLE, trigger with next_row<GRID_ROWS: latch next_row, col<=0, go to FETCH.
  - FETCH: each cycle cell_rd_en=1, cell_rd_addr=row*GRID_COLS+col, col++. After issuing col GRID_COLS-1, go to DRAIN.
  - Every cycle (FETCH or DRAIN) following a strobe: write cell_rd_data into line_buf[col-1].
  - DRAIN: one cycle to capture the last word, then row_valid<=1 and go to IDLE.
- Fetch length: GRID_COLS strobe cycles plus 1 drain cycle, i.e. GRID_COLS+1 cycles after the trigger.
- fetch_busy = (state != IDLE).
- Triggers arriving outside IDLE are ignored and set overrun.
- overrun also sets when fetch_busy=1 and pixel_x==1. It clears only on reset.
- Output lookup (combinational): cell_x = pixel_x >> CELL_W_LOG2.
  - If row_valid && cell_x<GRID_COLS: {R,G,B} = line_buf[cell_x].
  - Otherwise: {R,G,B} = BG_COLOR.
  - The downstream controller gates outputs with its visible window; this block does not.
- The line buffer is read and written in the same clock, but writes occur only during h-blank, so there is no read/write hazard in the visible region.
- Widths: row*GRID_COLS is computed at ADDR_BITS and truncated. col counter is $clog2(GRID_COLS+1) bits.

Decomposition:
- vga_pkg additions:
  - typedef vga_color_t (3-bit {R,G,B}).
  - struct vga_grid_params_t (cell_w_log2, cell_h_log2, grid_cols, grid_rows, bg_color).
  - fetch_state_t enum {IDLE, FETCH, DRAIN}.
- Sub-module vga_line_buffer: GRID_COLS x vga_color_t register array.
  - One synchronous write port.
  - One combinational read port.
  - Synchronous clear-to-BG on reset.

Test Plan:
- Reset mid-fetch (assert at the 4th FETCH cycle) -> next cycle fetch_busy=0, cell_rd_en=0; outputs BG_COLOR for any pixel_x.
- Sweep pixel_x 0..799 with pixel_y=15; RAM model returns data=addr[2:0] -> reads at addrs 10..19 in 10 consecutive cycles after x=639; then at y=16, x=16..31 outputs color 3'b011 (addr 11).
- Line with pixel_y=319 (next_row=20 >= GRID_ROWS) -> no cell_rd_en; all pixels next line BG_COLOR.
- pixel_x ≥ 160 (cell_x ≥ 10) on a valid row -> BG_COLOR.
- pixel_y=479 at pixel_x=639 -> frame_tick=1 for exactly one cycle; fetch reads row 0 (addrs 0..9).
- Force a second trigger 5 cycles after the first (fetch still busy) -> trigger ignored, overrun=1 and stays 1 until reset; repeat with pixel_x=1 while busy -> overrun=1.
